sum_tx_sequencer: RTL and testbench
===================================

Name: sum_tx_sequencer

Overview:
Control block for the sum-latch UART datapath.
- Conditions the two active-low save buttons: synchronises, debounces and detects press edges.
- Latches two 5-bit operands from the shared data input and forms their 6-bit sum.
- Drives the byte-level UART transmitter through a start/busy handshake to send the sum as two uppercase ASCII hex digits followed by CR LF.
- Sits between the board pins and the UART TX, replacing ad-hoc glue in the top level.

Parameters:
- DATA_W, 5: operand width; sum is DATA_W+1 bits.
- DEBOUNCE_CYCLES, 50000: consecutive stable synchronised cycles before a button level is accepted; minimum 2.
- ACK_TIMEOUT, 3: cycles to wait for tx_busy to rise after tx_start before continuing.

Ports:
- clk, input, 1: system clock; all state on rising edge.
- reset, input, 1: synchronous, active-high reset.
- save_a_n, input, 1: operand-A button, active low, asynchronous to clk.
- save_b_n, input, 1: operand-B button, active low, asynchronous to clk.
- data_input, input, DATA_W: operand value; sampled raw on a press event.
- tx_busy, input, 1: UART transmitter busy.
- tx_start, output, 1: one-cycle request to send tx_data.
- tx_data, output, 8: byte to transmit.
- a_valid, output, 1: operand A held.
- b_valid, output, 1: operand B held.
- sum_out, output, DATA_W+1: last computed sum.
- seq_busy, output, 1: high whenever FSM is not IDLE.

Behaviour:
- Reset (sync, active-high, takes effect at next clk edge):
  - tx_start=0, tx_data=0x00, a_valid=0, b_valid=0, sum_out=0, seq_busy=0, FSM=IDLE, byte index=0.
  - Synchroniser flops and debounced levels = 1 (released); debounce counters = 0.
  - Reset mid-transmission aborts immediately; no further tx_start. The UART may finish its current byte.
- Input conditioning, per button:
  - 2-flop synchroniser.
  - Debounce counter increments while the synchronised value differs from the debounced level; it clears whenever they match.
  - When the count reaches DEBOUNCE_CYCLES-1, the debounced level toggles and the counter clears.
  - Press event = one-cycle pulse on debounced 1->0; release generates no event.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
  - Latency from pin edge to press event = 2 + DEBOUNCE_CYCLES cycles.
- Operand capture (IDLE only):
  - press_a: op_a <= data_input, a_valid <= 1. Same for B.
  - A repeat press overwrites the held operand.
  - Simultaneous press_a and press_b latch the same data_input into both.
  - Presses while seq_busy=1 are discarded; operands are unchanged.
- FSM states: IDLE, SUM, SEND, WAIT_ACK, WAIT_DONE, CLEAR.
  - IDLE -> SUM when a_valid&b_valid. This may be the cycle after the second capture.
  - SUM: sum_out <= op_a+op_b (zero-extended, no overflow; max 62). Build bytes:
    - b0 = hex(sum[5:4])
    - b1 = hex(sum[3:0])
    - b2 = 0x0D
    - b3 = 0x0A
    - hex mapping: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
    - Index <= 0. Next state SEND.
  - SEND: wait while tx_busy=1. When tx_busy=0: tx_start=1 for exactly one cycle, tx_data=b[index]. Next state WAIT_ACK.
  - WAIT_ACK: move to WAIT_DONE when tx_busy=1, or after ACK_TIMEOUT cycles without it.
  - WAIT_DONE: wait for tx_busy=0. Then if index=3 go to CLEAR; else index+1 and go to SEND.
  - CLEAR: a_valid <= 0, b_valid <= 0. Next state IDLE.
- Output holding:
  - tx_data holds its value from tx_start until the next byte is loaded; it retains the last byte in IDLE.
  - sum_out holds until the next SUM or reset.
- Throughput: one 4-byte frame per operand pair. tx_start is never asserted while tx_busy=1.

Test Plan:
- Reset, then A press with data 20, B press with data 17 -> a_valid, b_valid set; sum_out=37; tx_data sequence 0x32,0x35,0x0D,0x0A; four single-cycle tx_start pulses; a_valid=b_valid=0 after frame.
- A=31, B=31 -> sum_out=62; bytes 0x33,0x45,0x0D,0x0A. A=0, B=0 -> 0x30,0x30,0x0D,0x0A.
- save_a_n low pulse of DEBOUNCE_CYCLES-2 cycles (test with DEBOUNCE_CYCLES=8) -> no capture. Bouncing edge followed by stable low -> exactly one capture.
- Both buttons pressed in the same cycle with data 9 -> sum_out=18; bytes 0x31,0x32,0x0D,0x0A. Press during frame transmission -> ignored, frame unchanged, no second frame.
- UART model with 10-cycle busy and another model that never raises busy -> all 4 bytes sent in order. With the no-busy model, each byte advances after ACK_TIMEOUT cycles.
- Reset asserted after the second byte's tx_start -> next cycle all outputs at reset values, no further tx_start. A new A/B pair then produces a full frame.

Source files
------------

// File: rtl/sum_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sum_tx_sequencer
// Description : Conditions the two active-low save buttons (2-flop sync,
//               debounce, press-edge detect), latches two DATA_W-bit operands
//               from data_input, forms their sum and sends it to a byte UART
//               as two uppercase ASCII hex digits followed by CR LF using a
//               tx_start / tx_busy handshake.
// Ports       : clk, reset (sync, active-high)
//               save_a_n, save_b_n  - raw active-low buttons (asynchronous)
//               data_input          - operand value sampled on a press
//               tx_busy             - UART busy
//               tx_start, tx_data   - one-cycle send request and its byte
//               a_valid, b_valid    - operand held flags
//               sum_out             - last computed sum
//               seq_busy            - sequencer not idle
// Revision    : 1.0 - initial release
// ============================================================================
module sum_tx_sequencer #(
    parameter int DATA_W          = 5,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACK_TIMEOUT     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              save_a_n,
    input  logic              save_b_n,
    input  logic [DATA_W-1:0] data_input,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              a_valid,
    output logic              b_valid,
    output logic [DATA_W:0]   sum_out,
    output logic              seq_busy
);

    localparam int                c_DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DB_W-1:0] c_DB_MAX = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int                c_ACK_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [c_ACK_W-1:0] c_ACK_MAX = c_ACK_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SUM       = 3'd1,
        S_SEND      = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_CLEAR     = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Button conditioning: index 0 = A, index 1 = B
    // ------------------------------------------------------------------
    logic [1:0] w_pins;
    logic [1:0] w_press;

    assign w_pins = {save_b_n, save_a_n};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic              r_sync1;
            logic              r_sync2;
            logic              r_db;
            logic [c_DB_W-1:0] r_cnt;
            logic              w_expire;

            // The level flips when the mismatch has persisted long enough;
            // a press is that flip taken from released (1) to pressed (0).
            assign w_expire     = (r_sync2 != r_db) && (r_cnt == c_DB_MAX);
            assign w_press[gi]  = w_expire && r_db;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync1 <= 1'b1;
                    r_sync2 <= 1'b1;
                    r_db    <= 1'b1;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_pins[gi];
                    r_sync2 <= r_sync1;
                    if (r_sync2 == r_db) begin
                        r_cnt <= '0;
                    end else if (w_expire) begin
                        r_db  <= ~r_db;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_fire;
    logic [DATA_W-1:0]   r_op_a;
    logic [DATA_W-1:0]   r_op_b;
    logic                r_a_valid;
    logic                r_b_valid;
    logic [DATA_W:0]     r_sum;
    logic [1:0]          r_idx;
    logic [c_ACK_W-1:0]  r_ack_cnt;
    logic                r_tx_start;
    logic [7:0]          r_tx_data;
    logic [7:0]          w_sum8;
    logic [7:0]          w_byte;

    function automatic logic [7:0] f_hex(input logic [3:0] n);
        // 'A' - 10 = 0x37 gives the uppercase letters for 10..15
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // The sum is rendered as a full byte: upper nibble then lower nibble.
    assign w_sum8 = 8'(r_sum);

    always_comb begin
        w_byte = 8'h0A;
        case (r_idx)
            2'd0:    w_byte = f_hex(w_sum8[7:4]);
            2'd1:    w_byte = f_hex(w_sum8[3:0]);
            2'd2:    w_byte = 8'h0D;
            default: w_byte = 8'h0A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fire      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_a_valid && r_b_valid) w_state_nxt = S_SUM;
            end
            S_SUM: begin
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (!tx_busy) begin
                    w_fire      = 1'b1;
                    w_state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // A UART that never reports busy must not stall the frame.
                if (tx_busy || (r_ack_cnt == c_ACK_MAX)) w_state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!tx_busy) w_state_nxt = (r_idx == 2'd3) ? S_CLEAR : S_SEND;
            end
            S_CLEAR: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_a_valid  <= 1'b0;
            r_b_valid  <= 1'b0;
            r_sum      <= '0;
            r_idx      <= 2'd0;
            r_ack_cnt  <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_tx_start <= w_fire;
            if (w_fire) r_tx_data <= w_byte;

            // Presses outside IDLE are simply dropped.
            if (r_state == S_IDLE) begin
                if (w_press[0]) begin
                    r_op_a    <= data_input;
                    r_a_valid <= 1'b1;
                end
                if (w_press[1]) begin
                    r_op_b    <= data_input;
                    r_b_valid <= 1'b1;
                end
            end

            if (r_state == S_SUM) begin
                r_sum <= {1'b0, r_op_a} + {1'b0, r_op_b};
                r_idx <= 2'd0;
            end

            if ((r_state == S_WAIT_DONE) && !tx_busy && (r_idx != 2'd3)) begin
                r_idx <= r_idx + 2'd1;
            end

            if (r_state == S_WAIT_ACK) r_ack_cnt <= r_ack_cnt + 1'b1;
            else                       r_ack_cnt <= '0;

            if (r_state == S_CLEAR) begin
                r_a_valid <= 1'b0;
                r_b_valid <= 1'b0;
            end
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign a_valid  = r_a_valid;
    assign b_valid  = r_b_valid;
    assign sum_out  = r_sum;
    assign seq_busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sum_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_tx_sequencer
// Description : Self-checking bench for sum_tx_sequencer. Drives button
//               presses, models the UART busy behaviour, predicts every frame
//               from the operand values and compares each transmitted byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_tx_sequencer;

    localparam int DATA_W = 5;
    localparam int DB     = 8;
    localparam int ACK_TO = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              save_a_n = 1'b1;
    logic              save_b_n = 1'b1;
    logic [DATA_W-1:0] data_input = '0;
    logic              tx_busy;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              a_valid;
    logic              b_valid;
    logic [DATA_W:0]   sum_out;
    logic              seq_busy;

    sum_tx_sequencer #(
        .DATA_W          (DATA_W),
        .DEBOUNCE_CYCLES (DB),
        .ACK_TIMEOUT     (ACK_TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .save_a_n   (save_a_n),
        .save_b_n   (save_b_n),
        .data_input (data_input),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .a_valid    (a_valid),
        .b_valid    (b_valid),
        .sum_out    (sum_out),
        .seq_busy   (seq_busy)
    );

    always #5 clk = ~clk;

    // UART model: mode 1 = busy for 10 cycles per byte, mode 0 = never busy
    int uart_mode = 1;
    int busy_cnt  = 0;
    always @(posedge clk) begin
        if (uart_mode == 1 && tx_start) busy_cnt <= 10;
        else if (busy_cnt > 0)          busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    // Bookkeeping
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    int         exp_sum = 0;
    bit         mon_en = 0;
    logic [7:0] last_byte = 8'h00;
    bit         prev_start = 0;
    bit         prev_busy = 0;
    int         frame_bytes = 0;
    int         frames_done = 0;
    int         start_cnt = 0;
    int         cyc = 0;
    int         last_start_cyc = 0;
    logic [7:0] got[4];

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ASCII '0' = 48, 'A' = 65
    function automatic logic [7:0] hex_char(input int v);
        if (v < 10) return 8'(48 + v);
        return 8'(65 + v - 10);
    endfunction

    task automatic expect_pair(input int a, input int b);
        exp_sum = a + b;
        exp_q.push_back(hex_char(exp_sum / 16));
        exp_q.push_back(hex_char(exp_sum % 16));
        exp_q.push_back(8'd13);
        exp_q.push_back(8'd10);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                if (seq_busy && !prev_busy) begin
                    chk(a_valid && b_valid, "valid_at_frame_start", {a_valid, b_valid}, 3);
                    frame_bytes = 0;
                end
                if (tx_start) begin
                    chk(!tx_busy, "start_while_busy", tx_busy, 0);
                    chk(!prev_start, "start_single_cycle", prev_start, 0);
                    chk(int'(sum_out) == exp_sum, "sum_at_send", sum_out, exp_sum);
                    if (uart_mode == 0 && frame_bytes > 0)
                        chk((cyc - last_start_cyc) >= ACK_TO + 1 && (cyc - last_start_cyc) <= ACK_TO + 4,
                            "no_busy_byte_gap", cyc - last_start_cyc, ACK_TO + 2);
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_tx_start", tx_data, 0);
                    end else begin
                        last_byte = exp_q.pop_front();
                        chk(tx_data == last_byte, "tx_byte", tx_data, last_byte);
                    end
                    if (frame_bytes < 4) got[frame_bytes] = tx_data;
                    frame_bytes++;
                    start_cnt++;
                    last_start_cyc = cyc;
                end else begin
                    chk(tx_data == last_byte, "tx_data_hold", tx_data, last_byte);
                end
                if (!seq_busy && prev_busy) begin
                    chk(frame_bytes == 4, "bytes_per_frame", frame_bytes, 4);
                    chk(!a_valid && !b_valid, "valid_cleared", {a_valid, b_valid}, 0);
                    frames_done++;
                end
                prev_start = tx_start;
                prev_busy  = seq_busy;
            end
        end
    endtask

    task automatic press(input bit do_a, input bit do_b, input int data);
        data_input = DATA_W'(data);
        if (do_a) save_a_n = 1'b0;
        if (do_b) save_b_n = 1'b0;
        repeat (DB + 6) @(negedge clk);
        save_a_n = 1'b1;
        save_b_n = 1'b1;
        repeat (DB + 6) @(negedge clk);
    endtask

    task automatic wait_frame(input int base);
        int t;
        t = 0;
        while (frames_done <= base && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk(frames_done == base + 1, "frame_completed", frames_done, base + 1);
    endtask

    task automatic check_got(input string name, input logic [7:0] b0, input logic [7:0] b1);
        chk(got[0] == b0, {name, "_b0"}, got[0], b0);
        chk(got[1] == b1, {name, "_b1"}, got[1], b1);
        chk(got[2] == 8'h0D, {name, "_b2"}, got[2], 8'h0D);
        chk(got[3] == 8'h0A, {name, "_b3"}, got[3], 8'h0A);
    endtask

    initial begin
        int base;
        int t;
        fork
            monitor();
        join_none

        // Reset values
        repeat (3) @(negedge clk);
        chk(tx_start == 1'b0, "rst_tx_start", tx_start, 0);
        chk(tx_data == 8'h00, "rst_tx_data", tx_data, 0);
        chk(!a_valid && !b_valid, "rst_valid", {a_valid, b_valid}, 0);
        chk(sum_out == 6'd0, "rst_sum", sum_out, 0);
        chk(seq_busy == 1'b0, "rst_seq_busy", seq_busy, 0);
        reset = 1'b0;
        mon_en = 1;

        // 20 + 17 = 37 -> "25"
        base = frames_done;
        expect_pair(20, 17);
        press(1, 0, 20);
        chk(a_valid == 1'b1, "a_captured", a_valid, 1);
        chk(b_valid == 1'b0, "b_not_yet", b_valid, 0);
        press(0, 1, 17);
        wait_frame(base);
        chk(sum_out == 6'd37, "sum_37", sum_out, 37);
        check_got("frame37", 8'h32, 8'h35);

        // 31 + 31 = 62 -> "3E"
        base = frames_done;
        expect_pair(31, 31);
        press(1, 0, 31);
        press(0, 1, 31);
        wait_frame(base);
        chk(sum_out == 6'd62, "sum_62", sum_out, 62);
        check_got("frame62", 8'h33, 8'h45);

        // 0 + 0 -> "00"
        base = frames_done;
        expect_pair(0, 0);
        press(1, 0, 0);
        press(0, 1, 0);
        wait_frame(base);
        check_got("frame0", 8'h30, 8'h30);

        // Glitch of DB-2 cycles: no capture
        data_input = 5'd7;
        save_a_n = 1'b0;
        repeat (DB - 2) @(negedge clk);
        save_a_n = 1'b1;
        repeat (3 * DB) @(negedge clk);
        chk(a_valid == 1'b0, "glitch_ignored", a_valid, 0);

        // Bouncing press then stable low: one capture with data 11
        base = frames_done;
        expect_pair(11, 4);
        data_input = 5'd11;
        foreach (got[i]) got[i] = 8'h00;
        begin
            bit bounce[7] = '{0, 1, 0, 0, 1, 0, 1};
            foreach (bounce[i]) begin
                save_a_n = bounce[i];
                @(negedge clk);
            end
            save_a_n = 1'b0;
            repeat (DB + 6) @(negedge clk);
            data_input = 5'd25;
            save_a_n = 1'b1;
            @(negedge clk);
            save_a_n = 1'b0;
            @(negedge clk);
            save_a_n = 1'b1;
            repeat (DB + 6) @(negedge clk);
        end
        chk(a_valid == 1'b1, "bounce_capture", a_valid, 1);
        press(0, 1, 4);
        wait_frame(base);
        chk(sum_out == 6'd15, "sum_15", sum_out, 15);
        check_got("frame15", 8'h30, 8'h46);

        // Both buttons in the same cycle with 9 -> 18
        base = frames_done;
        expect_pair(9, 9);
        press(1, 1, 9);
        wait_frame(base);
        chk(sum_out == 6'd18, "sum_18", sum_out, 18);
        check_got("frame18", 8'h31, 8'h32);

        // Press during transmission is ignored
        base = frames_done;
        expect_pair(5, 6);
        press(1, 0, 5);
        press(0, 1, 6);
        chk(seq_busy == 1'b1, "busy_before_late_press", seq_busy, 1);
        press(1, 0, 1);
        wait_frame(base);
        repeat (40) @(negedge clk);
        chk(frames_done == base + 1, "no_second_frame", frames_done, base + 1);
        chk(a_valid == 1'b0, "late_press_discarded", a_valid, 0);
        check_got("frame11", 8'h30, 8'h42);

        // UART that never raises busy: ack timeout path
        uart_mode = 0;
        base = frames_done;
        expect_pair(10, 26);
        press(1, 0, 10);
        press(0, 1, 26);
        wait_frame(base);
        check_got("frame36", 8'h32, 8'h34);

        // Reset after the second byte
        uart_mode = 1;
        base = start_cnt;
        expect_pair(1, 2);
        press(1, 0, 1);
        save_b_n = 1'b0;
        data_input = 5'd2;
        t = 0;
        while (start_cnt < base + 2 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk(start_cnt == base + 2, "reached_second_byte", start_cnt - base, 2);
        reset = 1'b1;
        mon_en = 0;
        save_b_n = 1'b1;
        @(negedge clk);
        chk(tx_start == 1'b0, "mid_rst_tx_start", tx_start, 0);
        chk(tx_data == 8'h00, "mid_rst_tx_data", tx_data, 0);
        chk(!a_valid && !b_valid, "mid_rst_valid", {a_valid, b_valid}, 0);
        chk(sum_out == 6'd0, "mid_rst_sum", sum_out, 0);
        chk(seq_busy == 1'b0, "mid_rst_seq_busy", seq_busy, 0);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk(tx_start == 1'b0, "no_start_after_rst", tx_start, 0);
        end
        exp_q.delete();
        last_byte = 8'h00;
        prev_start = 0;
        prev_busy = 0;
        exp_sum = 0;
        mon_en = 1;

        // Fresh pair after reset: 12 + 13 = 25 -> "19"
        base = frames_done;
        expect_pair(12, 13);
        press(1, 0, 12);
        press(0, 1, 13);
        wait_frame(base);
        chk(sum_out == 6'd25, "sum_25", sum_out, 25);
        check_got("frame25", 8'h31, 8'h39);
        chk(exp_q.size() == 0, "all_expected_sent", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
